gate_sweep_controller: RTL and testbench
========================================

Name: gate_sweep_controller

Overview:
Self-test sequencer for a 2-input combinational gate (and_gate by default). On start it drives X/Y through all four input vectors, waits a settle time, samples F and compares it with an expected truth table. It reports a mismatch count, a per-vector fail mask and a pass flag. It sits beside the gate in a wrapper (gate_sweep_top), driving the gate's X/Y and reading its F.

Parameters:
SETTLE, 1, cycles X/Y are held before F is sampled (0..15; 0 means sample in the cycle after drive)
EXP_TABLE, 4'b1000, expected F per vector index i={X,Y}; bit i = expected F (AND default)
CNT_W, 4, settle counter width; SETTLE <= 2**CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin a sweep; honoured only in IDLE
abort  in  1  cancel a running sweep
F  in  1  gate output under test
X  out  1  gate input X, registered
Y  out  1  gate input Y, registered
busy  out  1  high in WAIT/SAMPLE
done  out  1  one-cycle pulse at end of a completed sweep
pass  out  1  1 when the last completed sweep had zero mismatches; held until next start
err_count  out  3  mismatches in current/last sweep (0..4)
fail_mask  out  4  bit i set if vector i mismatched

Behaviour:
- Reset (async, any state): state=IDLE, X=Y=0, busy=done=pass=0, err_count=0, fail_mask=0, idx=0, cnt=0.
- Vector order: idx 0,1,2,3; X=idx[1], Y=idx[0]. X/Y are registers loaded on the edge entering WAIT (or SAMPLE if SETTLE=0). They are stable until the next load.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: if start=1, load idx=0, X/Y=vector 0, cnt=SETTLE-1, and clear err_count, fail_mask and pass. Go to WAIT, or to SAMPLE if SETTLE=0.
- WAIT: decrement cnt; when cnt==0, go to SAMPLE.
- SAMPLE: if F != EXP_TABLE[idx], err_count+=1 and fail_mask[idx]=1.
  - If idx<3: idx+=1, load the next vector, reload cnt, go to WAIT (or SAMPLE if SETTLE=0).
  - If idx==3: go to DONE; pass is computed including this sample.
- DONE: done=1 for exactly this cycle, X=Y=0, go to IDLE. start is ignored in DONE.
- Latency: done is high in the cycle following edge 4*(SETTLE+1) counted from the start-accepting edge. SETTLE=1 gives 8 edges; SETTLE=0 gives 4.
- F is sampled only in SAMPLE; F glitches during WAIT are ignored.
- start while busy or in DONE: ignored, with no restart and no effect on counters.
- abort in WAIT or SAMPLE: go to IDLE, X=Y=0, no done pulse, pass=0. The SAMPLE compare in that cycle is discarded, but partial err_count/fail_mask are kept. abort has priority over the sample. abort in IDLE/DONE has no effect.
- start and abort both high in IDLE: start is accepted (abort only acts on running sweeps).
- err_count never exceeds 4, so no saturation logic is needed. pass = (fail_mask==0) registered on the DONE entry edge.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Decomposition:
- Package gate_sweep_pkg holds:
  - State encoding localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_SAMPLE=2'd2, ST_DONE=2'd3.
  - Expected-table constants EXP_AND=4'b1000, EXP_OR=4'b1110, EXP_XOR=4'b0110, EXP_NAND=4'b0111.
- No sub-module inside the controller; the settle counter is inline.
- gate_sweep_top instantiates gate_sweep_controller plus and_gate (X,Y,F) and is the bench DUT.

Test Plan:
1. SETTLE=1, correct and_gate, pulse start -> done on 8th edge after start, pass=1, err_count=0, fail_mask=4'b0000, X/Y sequence 00,01,10,11.
2. Gate replaced by OR with EXP_TABLE=EXP_AND -> pass=0, err_count=2, fail_mask=4'b0110.
3. SETTLE=3, abort asserted during SAMPLE of idx=2 with wrong gate (OR) -> no done, busy low next cycle, X=Y=0, pass=0, fail_mask=4'b0010 (idx2 compare discarded).
4. start re-pulsed while busy and during DONE -> ignored; exactly one done per accepted start; second start in IDLE runs a fresh sweep with err_count cleared.
5. rst asserted asynchronously mid-WAIT (between clock edges) -> all outputs 0 immediately; next start runs a full sweep normally.
6. SETTLE=0, and_gate -> done on 4th edge after start, pass=1; F forced to 1 only during WAIT cycles with SETTLE=2 -> still pass=1.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared state encoding and expected truth tables
// for the gate self-test sweep.
package gate_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // bit i is the expected F for input vector i = {X,Y}
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_NAND = 4'b0111;

endpackage

// File: rtl/and_gate.sv
// Two-input AND gate; the default device
// exercised by the sweep controller.
module and_gate (
  input  logic X,
  input  logic Y,
  output logic F
);

  assign F = X & Y;

endmodule

// File: rtl/gate_sweep_top.sv
// Wrapper pairing the sweep controller with the
// gate it tests.
module gate_sweep_top
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE    = 1,
  parameter logic [3:0] EXP_TABLE = EXP_AND,
  parameter int         CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  logic x;
  logic y;
  logic f;

  gate_sweep_controller #(
    .SETTLE   (SETTLE),
    .EXP_TABLE(EXP_TABLE),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .F        (f),
    .X        (x),
    .Y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_mask(fail_mask)
  );

  and_gate u_gate (
    .X(x),
    .Y(y),
    .F(f)
  );

endmodule

// File: rtl/gate_sweep_controller.sv
// Drives all four X/Y vectors into a 2-input gate,
// samples F after a settle delay and scores it.
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int         SETTLE    = 1,
  parameter logic [3:0] EXP_TABLE = EXP_AND,
  parameter int         CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       F,
  output logic       X,
  output logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic [CNT_W-1:0] RELOAD =
    (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);

  // with no settle time each vector goes straight to sampling
  localparam state_t ST_RUN =
    (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [1:0]       idx_inc;
  logic [CNT_W-1:0] cnt;
  logic             miss;
  logic [3:0]       mask_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_WAIT: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (cnt == 0) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)            state_nxt = ST_IDLE;
        else if (idx == 2'd3) state_nxt = ST_DONE;
        else                  state_nxt = ST_RUN;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_WAIT:   busy = 1'b1;
      ST_SAMPLE: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    miss     = F != EXP_TABLE[idx];
    mask_nxt = fail_mask | ({3'b000, miss} << idx);
    idx_inc  = idx + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      cnt       <= '0;
      X         <= 1'b0;
      Y         <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            idx       <= '0;
            cnt       <= RELOAD;
            X         <= 1'b0;
            Y         <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            X    <= 1'b0;
            Y    <= 1'b0;
            pass <= 1'b0;
          end else if (cnt != 0) begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            X    <= 1'b0;
            Y    <= 1'b0;
            pass <= 1'b0;
          end else begin
            err_count <= err_count + 3'(miss);
            fail_mask <= mask_nxt;
            if (idx == 2'd3) begin
              X    <= 1'b0;
              Y    <= 1'b0;
              pass <= mask_nxt == 4'd0;
            end else begin
              idx <= idx_inc;
              X   <= idx_inc[1];
              Y   <= idx_inc[0];
              cnt <= RELOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Scoreboard bench: three controllers (SETTLE 1,3,0)
// driven by a timing-level model of the gate.
module tb_gate_sweep_controller;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int SV[3] = '{1, 3, 0};

  logic       start;
  logic       abort;
  logic       f;
  logic [1:0] sel;
  logic [2:0] start_v;
  logic [2:0] abort_v;

  logic       x_w[3];
  logic       y_w[3];
  logic       busy_w[3];
  logic       done_w[3];
  logic       pass_w[3];
  logic [2:0] err_w[3];
  logic [3:0] mask_w[3];

  always_comb begin
    start_v      = '0;
    abort_v      = '0;
    start_v[sel] = start;
    abort_v[sel] = abort;
  end

  gate_sweep_controller #(.SETTLE(1), .EXP_TABLE(EXP_AND), .CNT_W(4)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
    .F(f), .X(x_w[0]), .Y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .fail_mask(mask_w[0]));

  gate_sweep_controller #(.SETTLE(3), .EXP_TABLE(EXP_AND), .CNT_W(4)) u_s3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
    .F(f), .X(x_w[1]), .Y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .fail_mask(mask_w[1]));

  gate_sweep_controller #(.SETTLE(0), .EXP_TABLE(EXP_AND), .CNT_W(4)) u_s0 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
    .F(f), .X(x_w[2]), .Y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_count(err_w[2]), .fail_mask(mask_w[2]));

  typedef struct {
    int         done_cyc;
    logic [2:0] err;
    logic [3:0] mask;
    logic       pass;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  // monitor: every done pulse retires one expected sweep result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done_w[sel]) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("err_count", int'(err_w[sel]), int'(e.err));
        chk("fail_mask", int'(mask_w[sel]), int'(e.mask));
        chk("pass", int'(pass_w[sel]), int'(e.pass));
      end
    end
  end

  task automatic sweep(input int si, input logic [3:0] tt,
                       input int abort_c, input bit noise);
    int         s;
    int         d;
    int         smp;
    int         k;
    logic [3:0] m;
    logic [2:0] e;
    s   = SV[si];
    d   = 4 * (s + 1);
    sel = 2'(si);
    m   = '0;
    e   = '0;
    for (int i = 0; i < 4; i++)
      if (abort_c < 0 || i * (s + 1) + s < abort_c)
        if (tt[i] != EXP_AND[i]) begin
          m[i] = 1'b1;
          e    = e + 3'd1;
        end
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = noise ? 1'($urandom % 2) : 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    k     = cyc;
    if (abort_c < 0) q.push_back('{k + d, e, m, m == 4'd0});
    for (int c = 0; c <= d; c++) begin
      smp = -1;
      for (int i = 0; i < 4; i++)
        if (c == i * (s + 1) + s) smp = i;
      if (smp >= 0) f = tt[smp];
      else          f = noise ? 1'($urandom % 2) : 1'b0;
      if (noise) start = 1'($urandom % 2);
      if (noise && c == d) abort = 1'($urandom % 2);
      if (c == abort_c) abort = 1'b1;
      @(negedge clk);
      chk("busy", int'(busy_w[sel]), int'(c < d));
      if (smp >= 0) chk("xy_vector", int'({x_w[sel], y_w[sel]}), smp);
      if (c == d) chk("xy_done", int'({x_w[sel], y_w[sel]}), 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (c == abort_c) begin
        chk("abort_busy", int'(busy_w[sel]), 0);
        chk("abort_xy", int'({x_w[sel], y_w[sel]}), 0);
        chk("abort_pass", int'(pass_w[sel]), 0);
        chk("abort_err", int'(err_w[sel]), int'(e));
        chk("abort_mask", int'(mask_w[sel]), int'(m));
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(input string nm, input int si);
    chk({nm, "_busy"}, int'(busy_w[si]), 0);
    chk({nm, "_done"}, int'(done_w[si]), 0);
    chk({nm, "_pass"}, int'(pass_w[si]), 0);
    chk({nm, "_xy"}, int'({x_w[si], y_w[si]}), 0);
    chk({nm, "_err"}, int'(err_w[si]), 0);
    chk({nm, "_mask"}, int'(mask_w[si]), 0);
  endtask

  task automatic reset_mid();
    sel = 2'd0;
    f   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_err", int'(err_w[0]), 2);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset", 0);
    @(negedge clk);
    rst = 1'b0;
    f   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         si;
    int         ac;
    logic [3:0] tt;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    f     = 1'b0;
    sel   = 2'd0;
    #12;
    for (int i = 0; i < 3; i++) check_zero("reset", i);
    @(negedge clk);
    rst = 1'b0;

    sweep(0, EXP_AND, -1, 1'b0);
    sweep(0, EXP_OR, -1, 1'b0);
    sweep(1, EXP_OR, 11, 1'b0);
    sweep(1, EXP_AND, -1, 1'b1);
    sweep(0, EXP_XOR, -1, 1'b1);
    sweep(2, EXP_AND, -1, 1'b0);
    reset_mid();
    sweep(0, EXP_AND, -1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      si = int'($urandom % 3);
      tt = 4'($urandom);
      ac = ($urandom % 3 == 0) ?
           int'($urandom_range(0, 4 * (SV[si] + 1) - 1)) : -1;
      sweep(si, tt, ac, 1'($urandom % 2));
    end

    repeat (5) @(posedge clk);
    chk("pending_done", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
